// File: rtl/color_manager_config_regs.sv
// Staged configuration register file for the Color Manager: accepts one write per
// handshake and commits it at a domain-safe point (UART idle, VGA frame end, color now).
module color_manager_config_regs #(
  parameter int                      C_ADDR_WIDTH       = 4,
  parameter int                      C_DATA_WIDTH       = 14,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_UART_BAUDRATE = 4'h1,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_UART_PARITY   = 4'h2,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_UART_STOP     = 4'h3,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_VGA_CONFIG    = 4'h4,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_VGA_QUADRAN   = 4'h5,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_VGA_COLOR     = 4'h6,
  parameter logic [2:0]              DEFAULT_BAUDRATE   = 3'd2,
  parameter logic [1:0]              DEFAULT_PARITY     = 2'd0,
  parameter logic                    DEFAULT_STOP       = 1'b0,
  parameter logic [1:0]              DEFAULT_RESOLUTION = 2'd0,
  parameter logic [1:0]              DEFAULT_QUADRAN    = 2'd0,
  parameter logic [C_DATA_WIDTH-1:0] DEFAULT_COLOR      = '0,
  parameter logic [15:0]             TIMEOUT_CYCLES     = 16'd50000
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [C_ADDR_WIDTH-1:0] C_Addr,
  input  logic [C_DATA_WIDTH-1:0] C_Data,
  input  logic                    C_Valid,
  output logic                    C_Rdy,
  input  logic                    UART_Busy,
  input  logic                    VGA_Frame_End,
  output logic [2:0]              Baudrate_Cfg,
  output logic [1:0]              Parity_Cfg,
  output logic                    Stop_Cfg,
  output logic [1:0]              Resolution_Cfg,
  output logic [1:0]              Quadran_Cfg,
  output logic [C_DATA_WIDTH-1:0] Color_Cfg,
  output logic                    UART_Cfg_Update,
  output logic                    VGA_Cfg_Update,
  output logic                    Color_Update,
  output logic                    Addr_Error,
  output logic                    Timeout_Error
);

  typedef enum logic [1:0] {IDLE, WAIT_UART, WAIT_VGA, WAIT_COLOR} state_t;

  state_t                  state_reg;
  logic [C_ADDR_WIDTH-1:0] stage_addr_reg;
  logic [C_DATA_WIDTH-1:0] stage_data_reg;
  logic [15:0]             count_reg;
  logic                    commit_ok;
  logic                    timeout_hit;

  assign C_Rdy = (state_reg == IDLE);

  always_comb begin
    commit_ok = 1'b0;
    case (state_reg)
      WAIT_UART:  commit_ok = !UART_Busy;
      WAIT_VGA:   commit_ok = VGA_Frame_End;
      WAIT_COLOR: commit_ok = 1'b1;
      default:    commit_ok = 1'b0;
    endcase
  end

  // Counter holds the number of wait edges already spent; the last allowed edge sees T-1.
  assign timeout_hit = (state_reg != IDLE) && (count_reg == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg       <= IDLE;
      stage_addr_reg  <= '0;
      stage_data_reg  <= '0;
      count_reg       <= '0;
      Baudrate_Cfg    <= DEFAULT_BAUDRATE;
      Parity_Cfg      <= DEFAULT_PARITY;
      Stop_Cfg        <= DEFAULT_STOP;
      Resolution_Cfg  <= DEFAULT_RESOLUTION;
      Quadran_Cfg     <= DEFAULT_QUADRAN;
      Color_Cfg       <= DEFAULT_COLOR;
      UART_Cfg_Update <= 1'b0;
      VGA_Cfg_Update  <= 1'b0;
      Color_Update    <= 1'b0;
      Addr_Error      <= 1'b0;
      Timeout_Error   <= 1'b0;
    end else begin
      UART_Cfg_Update <= 1'b0;
      VGA_Cfg_Update  <= 1'b0;
      Color_Update    <= 1'b0;
      Addr_Error      <= 1'b0;
      Timeout_Error   <= 1'b0;

      if (state_reg == IDLE) begin
        if (C_Valid) begin
          count_reg <= '0;
          if (C_Addr == ADDR_UART_BAUDRATE || C_Addr == ADDR_UART_PARITY ||
              C_Addr == ADDR_UART_STOP) begin
            stage_addr_reg <= C_Addr;
            stage_data_reg <= C_Data;
            state_reg      <= WAIT_UART;
          end else if (C_Addr == ADDR_VGA_CONFIG || C_Addr == ADDR_VGA_QUADRAN) begin
            stage_addr_reg <= C_Addr;
            stage_data_reg <= C_Data;
            state_reg      <= WAIT_VGA;
          end else if (C_Addr == ADDR_VGA_COLOR) begin
            stage_addr_reg <= C_Addr;
            stage_data_reg <= C_Data;
            state_reg      <= WAIT_COLOR;
          end else begin
            Addr_Error <= 1'b1;
          end
        end
      end else if (commit_ok) begin
        // Commit beats timeout when both land on the same edge.
        if (stage_addr_reg == ADDR_UART_BAUDRATE) Baudrate_Cfg   <= stage_data_reg[2:0];
        if (stage_addr_reg == ADDR_UART_PARITY)   Parity_Cfg     <= stage_data_reg[1:0];
        if (stage_addr_reg == ADDR_UART_STOP)     Stop_Cfg       <= stage_data_reg[0];
        if (stage_addr_reg == ADDR_VGA_CONFIG)    Resolution_Cfg <= stage_data_reg[1:0];
        if (stage_addr_reg == ADDR_VGA_QUADRAN)   Quadran_Cfg    <= stage_data_reg[1:0];
        if (stage_addr_reg == ADDR_VGA_COLOR)     Color_Cfg      <= stage_data_reg;
        UART_Cfg_Update <= (state_reg == WAIT_UART);
        VGA_Cfg_Update  <= (state_reg == WAIT_VGA);
        Color_Update    <= (state_reg == WAIT_COLOR);
        state_reg       <= IDLE;
      end else if (timeout_hit) begin
        stage_addr_reg <= '0;
        stage_data_reg <= '0;
        Timeout_Error  <= 1'b1;
        state_reg      <= IDLE;
      end else begin
        count_reg <= count_reg + 16'd1;
      end
    end
  end

endmodule
